// File: rtl/dca_matrix_row_buffer.sv
// Ping-pong matrix buffer: the LSU fills one bank row by row while the compute
// datapath reads the other bank's completed matrix at random row indices.
module dca_matrix_row_buffer #(
    parameter int MATRIX_NUM_ROW = 4,
    parameter int BW_TENSOR_ROW  = 128,
    parameter int BW_ROW_INDEX   = (MATRIX_NUM_ROW > 2) ? $clog2(MATRIX_NUM_ROW) : 1
) (
    input  logic                     clk,
    input  logic                     rstnn,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    input  logic                     load_tensor_row_wvalid,
    input  logic                     load_tensor_row_wlast,
    input  logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata,
    output logic                     load_tensor_row_wready,
    output logic                     mat_rvalid,
    input  logic [BW_ROW_INDEX-1:0]  mat_rindex,
    output logic [BW_TENSOR_ROW-1:0] mat_rdata,
    output logic [BW_ROW_INDEX:0]    mat_rnum_row,
    input  logic                     mat_release,
    output logic                     load_error
);

    localparam logic [BW_ROW_INDEX:0] LP_LAST_ROW = (BW_ROW_INDEX+1)'(MATRIX_NUM_ROW - 1);

    logic [1:0][MATRIX_NUM_ROW-1:0][BW_TENSOR_ROW-1:0] r_bank;
    logic [1:0][BW_ROW_INDEX:0]                        r_num_row;
    logic [1:0]                                        r_full;
    logic                                              r_wr_bank;
    logic                                              r_rd_bank;
    logic                                              r_load_error;
    logic [BW_ROW_INDEX:0]                             r_row_cnt;

    logic                  w_wr_fire;
    logic                  w_close;
    logic                  w_release;
    logic                  w_idx_ok;
    logic [BW_ROW_INDEX:0] w_rd_num;

    // wready looks only at registered full flags, so a same-cycle release never bypasses
    assign load_tensor_row_wready = enable & ~r_full[r_wr_bank];
    assign w_wr_fire  = load_tensor_row_wvalid & load_tensor_row_wready;
    assign w_close    = w_wr_fire & (load_tensor_row_wlast | (r_row_cnt == LP_LAST_ROW));
    assign w_release  = mat_release & r_full[r_rd_bank];

    assign w_rd_num     = r_num_row[r_rd_bank];
    assign w_idx_ok     = ({1'b0, mat_rindex} < w_rd_num);
    assign mat_rvalid   = r_full[r_rd_bank];
    assign mat_rnum_row = w_rd_num;
    assign mat_rdata    = (mat_rvalid && w_idx_ok) ? r_bank[r_rd_bank][mat_rindex] : '0;

    assign busy       = r_full[0] | r_full[1] | (r_row_cnt != '0);
    assign load_error = r_load_error;

    // Row storage carries no reset; stale rows are masked by full/num_row on read.
    always_ff @(posedge clk) begin
        if (w_wr_fire && !clear)
            r_bank[r_wr_bank][r_row_cnt[BW_ROW_INDEX-1:0]] <= load_tensor_row_wdata;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_full       <= '0;
            r_num_row    <= '0;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_row_cnt    <= '0;
            r_load_error <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                r_full       <= '0;
                r_num_row    <= '0;
                r_wr_bank    <= 1'b0;
                r_rd_bank    <= 1'b0;
                r_row_cnt    <= '0;
                r_load_error <= 1'b0;
            end else begin
                if (w_close) begin
                    r_full[r_wr_bank]    <= 1'b1;
                    r_num_row[r_wr_bank] <= r_row_cnt + 1'b1;
                    r_row_cnt            <= '0;
                    r_wr_bank            <= ~r_wr_bank;
                    // closing on the row limit without wlast means the matrix overran
                    if (!load_tensor_row_wlast)
                        r_load_error <= 1'b1;
                end else if (w_wr_fire) begin
                    r_row_cnt <= r_row_cnt + 1'b1;
                end
                // a full bank blocks writes, so this never targets the bank just closed
                if (w_release) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_buffer.sv
// Directed bench for dca_matrix_row_buffer: fill, read, overrun, release/close overlap, clear.
module tb_dca_matrix_row_buffer;

    logic         clk = 1'b0;
    logic         rstnn;
    logic         clear;
    logic         enable;
    logic         busy;
    logic         wvalid;
    logic         wlast;
    logic [127:0] wdata;
    logic         wready;
    logic         rvalid;
    logic [1:0]   rindex;
    logic [127:0] rdata;
    logic [2:0]   rnum;
    logic         release_i;
    logic         lerr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dca_matrix_row_buffer dut (
        .clk                    (clk),
        .rstnn                  (rstnn),
        .clear                  (clear),
        .enable                 (enable),
        .busy                   (busy),
        .load_tensor_row_wvalid (wvalid),
        .load_tensor_row_wlast  (wlast),
        .load_tensor_row_wdata  (wdata),
        .load_tensor_row_wready (wready),
        .mat_rvalid             (rvalid),
        .mat_rindex             (rindex),
        .mat_rdata              (rdata),
        .mat_rnum_row           (rnum),
        .mat_release            (release_i),
        .load_error             (lerr)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [127:0] d, input logic last);
        wvalid = 1'b1;
        wdata  = d;
        wlast  = last;
        tick();
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic rel();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] idx, input logic [127:0] exp);
        rindex = idx;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        rstnn = 1'b0; clear = 1'b0; enable = 1'b0;
        wvalid = 1'b0; wlast = 1'b0; wdata = '0;
        rindex = '0; release_i = 1'b0;
        #12;
        check("rst_wready_dis", wready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rnum", rnum, 0);
        check("rst_busy", busy, 0);
        check("rst_lerr", lerr, 0);
        enable = 1'b1;
        #1;
        check("rst_wready_en", wready, 1);
        rstnn = 1'b1;
        tick();

        // basic 4-row matrix into bank 0
        wr(128'h1, 0); wr(128'h2, 0); wr(128'h3, 0);
        check("t1_rvalid_pre", rvalid, 0);
        check("t1_busy_mid", busy, 1);
        wr(128'h4, 1);
        check("t1_rvalid", rvalid, 1);
        check("t1_rnum", rnum, 4);
        rd("t1_idx2", 2'd2, 128'h3);
        rd("t1_idx0", 2'd0, 128'h1);
        rel();
        check("t1_rel_rvalid", rvalid, 0);
        check("t1_rel_busy", busy, 0);

        // two back-to-back matrices (bank 1 then bank 0), no release
        for (int i = 0; i < 8; i++) wr(128'h11 + i, (i == 3) || (i == 7));
        check("t2_wready_full", wready, 0);
        check("t2_rvalid", rvalid, 1);
        rd("t2_m1_idx0", 2'd0, 128'h11);
        rd("t2_m1_idx3", 2'd3, 128'h14);
        // release with a write offered: the write must not slip in
        wvalid = 1'b1; wdata = 128'hAA; wlast = 1'b1; release_i = 1'b1;
        #1;
        check("t2_no_bypass", wready, 0);
        tick();
        wvalid = 1'b0; wlast = 1'b0; release_i = 1'b0;
        check("t2_wready_back", wready, 1);
        check("t2_m2_rnum", rnum, 4);
        for (int i = 0; i < 4; i++) rd($sformatf("t2_m2_idx%0d", i), 2'(i), 128'h15 + i);
        check("t2_busy", busy, 1);
        rel();
        check("t2_empty", rvalid, 0);

        // short matrix into bank 1
        wr(128'h21, 0); wr(128'h22, 1);
        check("t3_rnum", rnum, 2);
        rd("t3_idx1", 2'd1, 128'h22);
        rd("t3_idx3_zero", 2'd3, 128'h0);
        check("t3_lerr", lerr, 0);
        rel();

        // overrun: 5 rows, wlast only on the fifth
        wr(128'h31, 0); wr(128'h32, 0); wr(128'h33, 0);
        check("t4_lerr_pre", lerr, 0);
        wr(128'h34, 0);
        check("t4_lerr", lerr, 1);
        check("t4_m1_rnum", rnum, 4);
        check("t4_m1_rvalid", rvalid, 1);
        wr(128'h35, 1);
        rd("t4_m1_idx3", 2'd3, 128'h34);
        rel();
        check("t4_m2_rvalid", rvalid, 1);
        check("t4_m2_rnum", rnum, 1);
        rd("t4_m2_idx0", 2'd0, 128'h35);
        rd("t4_m2_idx1_zero", 2'd1, 128'h0);
        rel();

        // close of matrix B and release of matrix A on the same edge
        for (int i = 0; i < 4; i++) wr(128'h41 + i, i == 3);
        wr(128'h51, 0); wr(128'h52, 0); wr(128'h53, 0);
        release_i = 1'b1;
        wr(128'h54, 1);
        release_i = 1'b0;
        check("t5_rvalid", rvalid, 1);
        check("t5_rnum", rnum, 4);
        check("t5_busy", busy, 1);
        rd("t5_idx0", 2'd0, 128'h51);
        rd("t5_idx3", 2'd3, 128'h54);
        rel();
        check("t5_empty", rvalid, 0);

        // clear mid-fill, with a competing write that clear must win over
        wr(128'h61, 0); wr(128'h62, 0);
        check("t6_busy_mid", busy, 1);
        clear = 1'b1;
        wr(128'h99, 1);
        clear = 1'b0;
        check("t6_busy_clr", busy, 0);
        check("t6_rvalid_clr", rvalid, 0);
        check("t6_lerr_clr", lerr, 0);
        for (int i = 0; i < 4; i++) wr(128'h71 + i, i == 3);
        check("t6_rnum", rnum, 4);
        for (int i = 0; i < 4; i++) rd($sformatf("t6_idx%0d", i), 2'(i), 128'h71 + i);

        // enable low freezes state and blocks writes
        enable = 1'b0;
        #1;
        check("t7_wready_dis", wready, 0);
        rel();
        check("t7_frozen_rvalid", rvalid, 1);
        enable = 1'b1;
        rel();
        check("t7_rel_rvalid", rvalid, 0);
        check("t7_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dca_matrix_row_buffer.md
# dca_matrix_row_buffer

Ping-pong matrix buffer sitting directly downstream of the matrix LSU load path. It accepts tensor rows from the LSU's `load_tensor_row_w*` write channel and assembles them into complete matrices in two alternating banks. It presents each completed matrix to the compute datapath for random row reads until that datapath releases it. While one bank is being read, the LSU can fill the other.

## Interface
Parameters:
- `MATRIX_NUM_ROW`, default 4: rows per matrix (≥2).
- `BW_TENSOR_ROW`, default 128: bits per row.
- `BW_ROW_INDEX`, default `clog2(MATRIX_NUM_ROW)` (min 1): row index width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock; the only clock.
- `rstnn` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous soft reset.
- `enable` in 1: gates all state updates.
- `busy` out 1: any bank non-empty, or a fill is in progress.
- `load_tensor_row_wvalid` in 1: row offered by the LSU.
- `load_tensor_row_wlast` in 1: last row of the matrix.
- `load_tensor_row_wdata` in `BW_TENSOR_ROW`: row data.
- `load_tensor_row_wready` out 1: row accepted this cycle.
- `mat_rvalid` out 1: a completed matrix is readable.
- `mat_rindex` in `BW_ROW_INDEX`: row to read.
- `mat_rdata` out `BW_TENSOR_ROW`: selected row, combinational.
- `mat_rnum_row` out `BW_ROW_INDEX+1`: number of valid rows in the readable matrix.
- `mat_release` in 1: consume the readable matrix.
- `load_error` out 1: sticky; a matrix overran `MATRIX_NUM_ROW`.

## Operation
Storage:
- Two banks, each `MATRIX_NUM_ROW` × `BW_TENSOR_ROW` registers.
- Per bank: `full` flag and `num_row` count.
- Pointers: `wr_bank`, `rd_bank` (1 bit each).
- `row_cnt`, width `BW_ROW_INDEX+1`.

Write side:
- `wready = enable & ~full[wr_bank]`.
- On accept (`wvalid & wready`): store `wdata` at `bank[wr_bank][row_cnt]`.
- Close condition: `wlast`, or `row_cnt == MATRIX_NUM_ROW-1`.
- If the close condition holds:
  - set `full[wr_bank]`;
  - `num_row[wr_bank] = row_cnt+1`;
  - `row_cnt = 0`;
  - toggle `wr_bank`.
- Otherwise: `row_cnt = row_cnt+1`.
- Forced close (row `MATRIX_NUM_ROW-1` accepted without `wlast`) sets `load_error`.
  - Subsequent rows up to and including a `wlast` start a new matrix normally; no data is dropped silently.

Read side:
- `mat_rvalid = full[rd_bank]`.
- `mat_rnum_row = num_row[rd_bank]`.
- `mat_rdata = bank[rd_bank][mat_rindex]` when `mat_rindex < num_row[rd_bank]` and `mat_rvalid`; otherwise all zeros.
- `mat_release & mat_rvalid`: clear `full[rd_bank]` and toggle `rd_bank`.
- `mat_release` while `~mat_rvalid` is ignored.

Other rules:
- `busy = full[0] | full[1] | (row_cnt != 0)`.
- `clear` (when `enable`) resets all pointers, flags, counters and `load_error`. Bank data is not cleared.
- `enable` low freezes all state. `wready` is forced to 0.

## Timing
- Reset values: `wready` 1 (rises once `enable` is 1), `mat_rvalid` 0, `mat_rdata` 0, `mat_rnum_row` 0, `busy` 0, `load_error` 0.
- Write handshake completes in the same cycle. Stored data is visible the next cycle.
- Latency from the closing write edge to `mat_rvalid` high is 1 cycle. The first row is readable in that cycle.
- `mat_rdata` follows `mat_rindex` combinationally. There is no read latency.
- Both banks full: `wready` 0 until the cycle after a release.
  - A release and a write in the same cycle do not bypass; `wready` is derived from registered `full` only.
- Simultaneous close of bank B and release of bank A: both take effect at the same edge. Next cycle, `rd_bank` = B and `mat_rvalid` stays 1.
- Same-cycle close and release on the same bank is impossible, because a full bank blocks writes.
- `clear` and `rstnn` mid-fill discard the partial matrix; `row_cnt` returns to 0.
- `clear` has priority over a simultaneous write or release.

## Test plan
- Reset, `enable`=1, 4 rows 0x1..0x4 with `wlast` on row 4 → `mat_rvalid` rises 1 cycle later, `mat_rnum_row`=4, index 2 reads 0x3.
- 8 back-to-back rows (two matrices) with no release → `wready` drops after row 8. Release bank 0 → `wready` returns next cycle, then bank 1 reads rows 5..8.
- Short matrix: 2 rows with `wlast` on row 2 → `mat_rnum_row`=2, index 3 reads 0, `load_error` stays 0.
- Overrun: 5 rows, `wlast` only on row 5 → first matrix closes at row 4, `load_error`=1, second matrix has `num_row`=1 holding row 5.
- Closing write of matrix 2 and release of matrix 1 in the same cycle → next cycle `mat_rvalid`=1 with matrix 2 data, `busy`=1.
- `clear` after 2 of 4 rows → `busy`=0 and `row_cnt`=0. The next 4 rows form a correct matrix at bank 0.
